pia_bus_arbiter: RTL and testbench
==================================

Name: pia_bus_arbiter

Overview:
Shares one mc6821 PIA register port between two requesters, master 0 (CPU side) and master 1 (init/debug sequencer). Each access is issued to the PIA as a single-clock chip-select aligned to e_sync. The single-clock select is required because PIA data-register reads clear IRQ flags as a side effect, so duplicated selects are not allowed. Sits between the requesters and the PIA rs/cs/write/data ports.

Parameters:
FIXED_PRIORITY, 0, 0 = round-robin between masters; 1 = master 0 always wins ties.

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-high reset
e_sync  in  1  PIA E-phase enable; an access completes only on an edge where e_sync=1
m0_req  in  1  single-cycle request strobe, master 0
m0_write  in  1  1=write, 0=read; sampled with m0_req
m0_rs  in  2  PIA register select; sampled with m0_req
m0_wdata  in  8  write data; sampled with m0_req
m0_busy  out  1  master 0 request pending or in flight
m0_ack  out  1  one-cycle completion pulse
m0_rdata  out  8  read data; valid from m0_ack, held until next master-0 read completes
m1_req, m1_write, m1_rs, m1_wdata, m1_busy, m1_ack, m1_rdata: same as master 0, for master 1
pia_cs  out  1  to PIA cs
pia_write  out  1  to PIA write
pia_rs  out  2  to PIA rs
pia_data_in  out  8  to PIA data_in
pia_data_out  in  8  from PIA data_out (combinational)

Behaviour:
- Per-master pending buffer {valid, write, rs, wdata}.
  - mX_req=1 while that buffer is not valid: loads the buffer; valid=1 from the next cycle.
  - mX_req while mX_busy=1: ignored, no state change.
- mX_busy = pending valid OR (granted to X and state != IDLE).
- FSM states: IDLE, ISSUE, ACK.
  - IDLE: if any pending is valid, choose a grant.
    - Round-robin: on a tie, grant the master not granted last. last_grant resets to 1, so master 0 wins the first tie.
    - FIXED_PRIORITY=1: master 0 wins ties.
    - Granting copies the buffer to the issue registers, clears that master's pending valid, and moves to ISSUE.
  - ISSUE: pia_cs = (state==ISSUE) & e_sync, combinational from the state register.
    - On the edge where e_sync=1: latch pia_data_out into mX_rdata if it was a read, then go to ACK.
    - Otherwise remain in ISSUE.
    - pia_cs is therefore high for exactly one clock per access.
  - ACK: mX_ack=1 for one cycle, then IDLE.
- pia_write, pia_rs, pia_data_in are driven from the issue registers and are stable through ISSUE. They hold their last value in IDLE and ACK.
- Latency: req in cycle 0, pending in cycle 1, ISSUE from cycle 2, ack in cycle 3 if e_sync=1 in cycle 2. The minimum is 3 cycles; each e_sync=0 cycle in ISSUE adds one.
- Back-to-back throughput is one access per 3 cycles.
- A new request may be strobed in the cycle after ack (busy=0).
- Reset values:
  - state=IDLE, all pending valid=0, last_grant=1.
  - pia_cs=0, pia_write=0, pia_rs=0, pia_data_in=0.
  - mX_ack=0, mX_rdata=0, mX_busy=0.
- Reset mid-access: pia_cs drops immediately (asynchronous), the in-flight access is discarded, and no ack is issued.
- mX_rdata is unchanged on write completions.

Optional Feature:
- Macro: PIA_BUS_ARBITER_LOCK_EN.
- When defined, two extra inputs are added: m0_lock and m1_lock (1 bit each).
- If the granted master's lock=1 during its ACK cycle, the arbiter stays locked to it:
  - IDLE grants only that master's pending request, even if the other master is pending and round-robin would favour it.
  - IDLE waits while that master has nothing pending and its lock stays high.
  - The lock releases when lock=0 is sampled in IDLE or in an ACK cycle.
- This makes the CRA-write / DDR-write / CRA-write configuration sequence atomic.
- When undefined, there are no lock ports and arbitration is purely per access.

Test Plan:
- m0 write rs=01 wdata=0x04, e_sync high every 4th cycle -> pia_cs high for exactly 1 cycle coincident with e_sync, with pia_rs=01, pia_write=1, pia_data_in=0x04; m0_ack pulses once on the next cycle.
- m1 read rs=00, pia_data_out=0xA5 at the e_sync edge -> m1_rdata=0xA5 with m1_ack; m0_rdata unchanged; pia_cs high 1 cycle only.
- m0 and m1 strobe in the same cycle, repeated 4 times, FIXED_PRIORITY=0 -> grant order m0,m1,m0,m1,... With FIXED_PRIORITY=1 -> m0 is served first every time.
- m0_req strobed again while m0_busy=1 -> second strobe ignored; exactly one pia_cs and one ack.
- Reset asserted while in ISSUE with e_sync=0 -> pia_cs=0 immediately; no ack; after release all outputs are 0 and busy=0.
- With PIA_BUS_ARBITER_LOCK_EN: m1 holds lock over 3 writes while m0 is pending -> m0 is served only after m1 drops lock; no interleaving.

Source files
------------

// File: rtl/pia_bus_arbiter.sv
// Two-master arbiter for one mc6821 PIA register port, one single-clock cs per access.
// Latency: req -> ack in 3 cycles minimum, plus one cycle per e_sync=0 cycle in ISSUE.
// Backpressure: mX_busy high while a request is pending or in flight; strobes while busy are dropped.
// Optional macro PIA_BUS_ARBITER_LOCK_EN adds m0_lock/m1_lock to hold the bus across accesses.
module pia_bus_arbiter #(
  parameter int FIXED_PRIORITY = 0
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       e_sync,
  input  logic       m0_req,
  input  logic       m0_write,
  input  logic [1:0] m0_rs,
  input  logic [7:0] m0_wdata,
  output logic       m0_busy,
  output logic       m0_ack,
  output logic [7:0] m0_rdata,
  input  logic       m1_req,
  input  logic       m1_write,
  input  logic [1:0] m1_rs,
  input  logic [7:0] m1_wdata,
  output logic       m1_busy,
  output logic       m1_ack,
  output logic [7:0] m1_rdata,
`ifdef PIA_BUS_ARBITER_LOCK_EN
  input  logic       m0_lock,
  input  logic       m1_lock,
`endif
  output logic       pia_cs,
  output logic       pia_write,
  output logic [1:0] pia_rs,
  output logic [7:0] pia_data_in,
  input  logic [7:0] pia_data_out
);

  typedef enum logic [1:0] {IDLE, ISSUE, ACK} state_t;

  state_t     state;
  logic       grant;       // master currently (or most recently) owning the PIA port
  logic       last_grant;  // round-robin history; resets to 1 so master 0 wins the first tie

  logic       p0_vld, p0_wr;
  logic [1:0] p0_rs;
  logic [7:0] p0_wd;
  logic       p1_vld, p1_wr;
  logic [1:0] p1_rs;
  logic [7:0] p1_wd;

  logic       do_grant;
  logic       grant_sel;

`ifdef PIA_BUS_ARBITER_LOCK_EN
  logic       locked;
  logic       own_lock;
  logic       own_pend;

  assign own_lock = grant ? m1_lock : m0_lock;
  assign own_pend = grant ? p1_vld : p0_vld;
`endif

  // The chip select is qualified by e_sync straight from the state register so it
  // drops the moment an asynchronous reset returns the FSM to IDLE.
  assign pia_cs  = (state == ISSUE) & e_sync;

  assign m0_ack  = (state == ACK) & ~grant;
  assign m1_ack  = (state == ACK) & grant;
  assign m0_busy = p0_vld | (~grant & (state != IDLE));
  assign m1_busy = p1_vld | (grant & (state != IDLE));

  // Grant decision in IDLE: tie-break by priority mode, overridden by an active lock.
  always_comb begin
    do_grant  = 1'b0;
    grant_sel = 1'b0;
    if (state == IDLE) begin
      if (p0_vld && p1_vld) begin
        do_grant  = 1'b1;
        grant_sel = (FIXED_PRIORITY != 0) ? 1'b0 : ~last_grant;
      end else if (p0_vld) begin
        do_grant  = 1'b1;
        grant_sel = 1'b0;
      end else if (p1_vld) begin
        do_grant  = 1'b1;
        grant_sel = 1'b1;
      end
`ifdef PIA_BUS_ARBITER_LOCK_EN
      // While locked only the owner may be served; with nothing pending we simply wait.
      if (locked && own_lock) begin
        do_grant  = own_pend;
        grant_sel = grant;
      end
`endif
    end
  end

  // Master 0 pending buffer: captured on an accepted strobe, cleared when granted.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      p0_vld <= 1'b0;
      p0_wr  <= 1'b0;
      p0_rs  <= 2'd0;
      p0_wd  <= 8'd0;
    end else if (do_grant && !grant_sel) begin
      p0_vld <= 1'b0;
    end else if (m0_req && !m0_busy) begin
      p0_vld <= 1'b1;
      p0_wr  <= m0_write;
      p0_rs  <= m0_rs;
      p0_wd  <= m0_wdata;
    end
  end

  // Master 1 pending buffer: captured on an accepted strobe, cleared when granted.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      p1_vld <= 1'b0;
      p1_wr  <= 1'b0;
      p1_rs  <= 2'd0;
      p1_wd  <= 8'd0;
    end else if (do_grant && grant_sel) begin
      p1_vld <= 1'b0;
    end else if (m1_req && !m1_busy) begin
      p1_vld <= 1'b1;
      p1_wr  <= m1_write;
      p1_rs  <= m1_rs;
      p1_wd  <= m1_wdata;
    end
  end

  // Access FSM: load issue registers on grant, wait for the e_sync edge, then ack for one cycle.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      grant       <= 1'b0;
      last_grant  <= 1'b1;
      pia_write   <= 1'b0;
      pia_rs      <= 2'd0;
      pia_data_in <= 8'd0;
      m0_rdata    <= 8'd0;
      m1_rdata    <= 8'd0;
    end else begin
      case (state)
        IDLE: begin
          if (do_grant) begin
            grant      <= grant_sel;
            last_grant <= grant_sel;
            state      <= ISSUE;
            if (grant_sel) begin
              pia_write   <= p1_wr;
              pia_rs      <= p1_rs;
              pia_data_in <= p1_wd;
            end else begin
              pia_write   <= p0_wr;
              pia_rs      <= p0_rs;
              pia_data_in <= p0_wd;
            end
          end
        end
        ISSUE: begin
          if (e_sync) begin
            if (!pia_write) begin
              if (grant) m1_rdata <= pia_data_out;
              else       m0_rdata <= pia_data_out;
            end
            state <= ACK;
          end
        end
        ACK: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

`ifdef PIA_BUS_ARBITER_LOCK_EN
  // Lock follows the owner's lock input in its ACK cycle and releases once seen low in IDLE.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      locked <= 1'b0;
    end else if (state == ACK) begin
      locked <= own_lock;
    end else if (state == IDLE && locked && !own_lock) begin
      locked <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_pia_bus_arbiter.sv
// Directed bench for pia_bus_arbiter: round-robin and fixed-priority instances share all inputs.
module tb_pia_bus_arbiter;

  logic       clock = 1'b0;
  logic       reset;
  logic       e_sync;
  logic       m0_req, m0_write, m1_req, m1_write;
  logic [1:0] m0_rs, m1_rs;
  logic [7:0] m0_wdata, m1_wdata;
  logic [7:0] pia_data_out;
`ifdef PIA_BUS_ARBITER_LOCK_EN
  logic       m0_lock, m1_lock;
`endif

  logic       rr_m0_busy, rr_m0_ack, rr_m1_busy, rr_m1_ack;
  logic [7:0] rr_m0_rdata, rr_m1_rdata;
  logic       rr_pia_cs, rr_pia_write;
  logic [1:0] rr_pia_rs;
  logic [7:0] rr_pia_data_in;
  logic       fp_m0_busy, fp_m0_ack, fp_m1_busy, fp_m1_ack;
  logic [7:0] fp_m0_rdata, fp_m1_rdata;
  logic       fp_pia_cs, fp_pia_write;
  logic [1:0] fp_pia_rs;
  logic [7:0] fp_pia_data_in;

  pia_bus_arbiter #(.FIXED_PRIORITY(0)) u_rr (
    .clock(clock), .reset(reset), .e_sync(e_sync),
    .m0_req(m0_req), .m0_write(m0_write), .m0_rs(m0_rs), .m0_wdata(m0_wdata),
    .m0_busy(rr_m0_busy), .m0_ack(rr_m0_ack), .m0_rdata(rr_m0_rdata),
    .m1_req(m1_req), .m1_write(m1_write), .m1_rs(m1_rs), .m1_wdata(m1_wdata),
    .m1_busy(rr_m1_busy), .m1_ack(rr_m1_ack), .m1_rdata(rr_m1_rdata),
`ifdef PIA_BUS_ARBITER_LOCK_EN
    .m0_lock(m0_lock), .m1_lock(m1_lock),
`endif
    .pia_cs(rr_pia_cs), .pia_write(rr_pia_write), .pia_rs(rr_pia_rs),
    .pia_data_in(rr_pia_data_in), .pia_data_out(pia_data_out)
  );

  pia_bus_arbiter #(.FIXED_PRIORITY(1)) u_fp (
    .clock(clock), .reset(reset), .e_sync(e_sync),
    .m0_req(m0_req), .m0_write(m0_write), .m0_rs(m0_rs), .m0_wdata(m0_wdata),
    .m0_busy(fp_m0_busy), .m0_ack(fp_m0_ack), .m0_rdata(fp_m0_rdata),
    .m1_req(m1_req), .m1_write(m1_write), .m1_rs(m1_rs), .m1_wdata(m1_wdata),
    .m1_busy(fp_m1_busy), .m1_ack(fp_m1_ack), .m1_rdata(fp_m1_rdata),
`ifdef PIA_BUS_ARBITER_LOCK_EN
    .m0_lock(m0_lock), .m1_lock(m1_lock),
`endif
    .pia_cs(fp_pia_cs), .pia_write(fp_pia_write), .pia_rs(fp_pia_rs),
    .pia_data_in(fp_pia_data_in), .pia_data_out(pia_data_out)
  );

  always #5 clock = ~clock;

  // Event monitor: counts chip selects and acks, records ack order (0 = m0, 1 = m1).
  int       cs_rr = 0, cs_fp = 0, ack_rr = 0, ack_fp = 0, n_rr = 0, n_fp = 0;
  bit       ord_rr[64];
  bit       ord_fp[64];
  bit [7:0] last_din_rr = 8'h00;

  always @(negedge clock) begin
    if (rr_pia_cs) begin
      cs_rr++;
      last_din_rr = rr_pia_data_in;
    end
    if (fp_pia_cs) cs_fp++;
    if (rr_m0_ack || rr_m1_ack) begin
      ack_rr++;
      if (n_rr < 64) begin ord_rr[n_rr] = rr_m1_ack; n_rr++; end
    end
    if (fp_m0_ack || fp_m1_ack) begin
      ack_fp++;
      if (n_fp < 64) begin ord_fp[n_fp] = fp_m1_ack; n_fp++; end
    end
  end

  int tests = 0;
  int fails = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  typedef struct {
    bit       m;
    bit       wr;
    bit [1:0] rs;
    bit [7:0] wd;
    bit [7:0] pdo;
    int       nwait;
    bit [7:0] exp_rd0;
    bit [7:0] exp_rd1;
  } vec_t;

  vec_t vecs[6];

  // One isolated access: strobe, wait nwait cycles in ISSUE, then an e_sync edge.
  task automatic run_vec(input vec_t v);
    int cs0, ack0;
    cs0 = cs_rr;
    ack0 = ack_rr;
    @(posedge clock); #1;
    e_sync = 1'b0;
    pia_data_out = v.pdo;
    if (!v.m) begin
      m0_req = 1'b1; m0_write = v.wr; m0_rs = v.rs; m0_wdata = v.wd;
    end else begin
      m1_req = 1'b1; m1_write = v.wr; m1_rs = v.rs; m1_wdata = v.wd;
    end
    @(posedge clock); #1;
    m0_req = 1'b0; m1_req = 1'b0;
    @(negedge clock);
    chk("vec_busy_pending", v.m ? rr_m1_busy : rr_m0_busy, 1);
    for (int w = 0; w < v.nwait; w++) begin
      @(posedge clock); #1;
      @(negedge clock);
      chk("vec_cs_low_wait", rr_pia_cs, 0);
    end
    @(posedge clock); #1;
    e_sync = 1'b1;
    @(negedge clock);
    chk("vec_cs_high", rr_pia_cs, 1);
    chk("vec_pia_write", rr_pia_write, v.wr);
    chk("vec_pia_rs", rr_pia_rs, v.rs);
    chk("vec_pia_data_in", rr_pia_data_in, v.wd);
    @(posedge clock); #1;
    e_sync = 1'b0;
    @(negedge clock);
    chk("vec_ack_owner", v.m ? rr_m1_ack : rr_m0_ack, 1);
    chk("vec_ack_other", v.m ? rr_m0_ack : rr_m1_ack, 0);
    chk("vec_cs_low_ack", rr_pia_cs, 0);
    chk("vec_rr_m0_rdata", rr_m0_rdata, v.exp_rd0);
    chk("vec_rr_m1_rdata", rr_m1_rdata, v.exp_rd1);
    chk("vec_fp_m0_rdata", fp_m0_rdata, v.exp_rd0);
    chk("vec_fp_m1_rdata", fp_m1_rdata, v.exp_rd1);
    @(posedge clock); #1;
    @(negedge clock);
    chk("vec_ack_cleared", {rr_m0_ack, rr_m1_ack}, 0);
    chk("vec_busy_cleared", {rr_m0_busy, rr_m1_busy}, 0);
    chk("vec_cs_count", cs_rr - cs0, 1);
    chk("vec_ack_count", ack_rr - ack0, 1);
  endtask

  int n0, f0, cs0, a0, sent;

  initial begin
    //                m   wr   rs    wdata  pdo    wait rd0    rd1
    vecs[0] = '{1'b0, 1'b1, 2'd1, 8'h04, 8'h00, 3, 8'h00, 8'h00};
    vecs[1] = '{1'b1, 1'b0, 2'd0, 8'h00, 8'hA5, 0, 8'h00, 8'hA5};
    vecs[2] = '{1'b0, 1'b0, 2'd2, 8'h00, 8'h3C, 1, 8'h3C, 8'hA5};
    vecs[3] = '{1'b1, 1'b1, 2'd3, 8'h7E, 8'hFF, 2, 8'h3C, 8'hA5};
    vecs[4] = '{1'b0, 1'b1, 2'd0, 8'h81, 8'h11, 0, 8'h3C, 8'hA5};
    vecs[5] = '{1'b1, 1'b0, 2'd1, 8'h00, 8'h5A, 4, 8'h3C, 8'h5A};

    reset = 1'b1; e_sync = 1'b0; pia_data_out = 8'h00;
    m0_req = 1'b0; m0_write = 1'b0; m0_rs = 2'd0; m0_wdata = 8'h00;
    m1_req = 1'b0; m1_write = 1'b0; m1_rs = 2'd0; m1_wdata = 8'h00;
`ifdef PIA_BUS_ARBITER_LOCK_EN
    m0_lock = 1'b0; m1_lock = 1'b0;
`endif
    repeat (2) @(negedge clock);
    chk("rst_cs", rr_pia_cs, 0);
    chk("rst_pia_regs", {rr_pia_write, rr_pia_rs, rr_pia_data_in}, 0);
    chk("rst_acks_busy", {rr_m0_ack, rr_m1_ack, rr_m0_busy, rr_m1_busy}, 0);
    chk("rst_rdata", {rr_m0_rdata, rr_m1_rdata}, 0);
    @(posedge clock); #1;
    reset = 1'b0;

    // Single accesses from the vector table
    for (int i = 0; i < 6; i++) run_vec(vecs[i]);

    // Simultaneous strobes, four times, e_sync always high: both modes serve m0 then m1
    e_sync = 1'b1;
    n0 = n_rr; f0 = n_fp;
    for (int k = 0; k < 4; k++) begin
      @(posedge clock); #1;
      m0_req = 1'b1; m0_write = 1'b1; m0_rs = 2'(k); m0_wdata = 8'(8'h10 + k);
      m1_req = 1'b1; m1_write = 1'b1; m1_rs = 2'(k); m1_wdata = 8'(8'h20 + k);
      @(posedge clock); #1;
      m0_req = 1'b0; m1_req = 1'b0;
      repeat (6) @(posedge clock);
    end
    @(negedge clock);
    chk("tie_rr_count", n_rr - n0, 8);
    chk("tie_fp_count", n_fp - f0, 8);
    for (int i = 0; i < 8; i++) begin
      chk("tie_rr_order", ord_rr[n0 + i], i % 2);
      chk("tie_fp_order", ord_fp[f0 + i], i % 2);
    end

    // m0 alone, then a tie: round-robin now favours m1, fixed priority still m0
    n0 = n_rr; f0 = n_fp;
    @(posedge clock); #1; m0_req = 1'b1;
    @(posedge clock); #1; m0_req = 1'b0;
    repeat (5) @(posedge clock);
    #1; m0_req = 1'b1; m1_req = 1'b1;
    @(posedge clock); #1; m0_req = 1'b0; m1_req = 1'b0;
    repeat (8) @(posedge clock);
    @(negedge clock);
    chk("rr2_count", n_rr - n0, 3);
    chk("rr2_first_tie_m1", ord_rr[n0 + 1], 1);
    chk("rr2_second_tie_m0", ord_rr[n0 + 2], 0);
    chk("fp2_first_tie_m0", ord_fp[f0 + 1], 0);
    chk("fp2_second_tie_m1", ord_fp[f0 + 2], 1);

    // Strobes while busy (pending and in flight) are dropped
    e_sync = 1'b0;
    cs0 = cs_rr; a0 = ack_rr;
    @(posedge clock); #1;
    m0_req = 1'b1; m0_write = 1'b1; m0_rs = 2'd2; m0_wdata = 8'h11;
    @(posedge clock); #1;
    m0_wdata = 8'h22;
    @(negedge clock);
    chk("busy_dup_pending", rr_m0_busy, 1);
    @(posedge clock); #1; m0_req = 1'b0;
    @(posedge clock); #1; m0_req = 1'b1; m0_wdata = 8'h33;
    @(negedge clock);
    chk("busy_dup_inflight", rr_m0_busy, 1);
    chk("busy_dup_cs_low", rr_pia_cs, 0);
    @(posedge clock); #1; m0_req = 1'b0; e_sync = 1'b1;
    @(negedge clock);
    chk("busy_dup_cs_high", rr_pia_cs, 1);
    @(posedge clock); #1; e_sync = 1'b0;
    repeat (4) @(posedge clock);
    @(negedge clock);
    chk("busy_dup_cs_count", cs_rr - cs0, 1);
    chk("busy_dup_ack_count", ack_rr - a0, 1);
    chk("busy_dup_data", last_din_rr, 8'h11);
    chk("busy_dup_idle", rr_m0_busy, 0);

    // Reset while in ISSUE with e_sync low
    a0 = ack_rr;
    @(posedge clock); #1; m1_req = 1'b1; m1_write = 1'b0; m1_rs = 2'd0; pia_data_out = 8'hC3;
    @(posedge clock); #1; m1_req = 1'b0;
    @(posedge clock); #1;
    @(negedge clock);
    chk("rstmid_in_issue", rr_m1_busy, 1);
    @(posedge clock); #1;
    reset = 1'b1;
    #1 e_sync = 1'b1;
    #1;
    chk("rstmid_rr_cs", rr_pia_cs, 0);
    chk("rstmid_fp_cs", fp_pia_cs, 0);
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    repeat (4) @(posedge clock);
    @(negedge clock);
    chk("rstmid_no_ack", ack_rr - a0, 0);
    chk("rstmid_pia_out", {rr_pia_cs, rr_pia_write, rr_pia_rs, rr_pia_data_in}, 0);
    chk("rstmid_busy", {rr_m0_busy, rr_m1_busy, fp_m0_busy, fp_m1_busy}, 0);
    chk("rstmid_rdata", {rr_m0_rdata, rr_m1_rdata}, 0);
    e_sync = 1'b0;

`ifdef PIA_BUS_ARBITER_LOCK_EN
    // m1 holds lock across three writes while m0 waits
    e_sync = 1'b1;
    n0 = n_rr; f0 = n_fp;
    m1_lock = 1'b1;
    @(posedge clock); #1; m1_req = 1'b1; m1_write = 1'b1; m1_rs = 2'd1; m1_wdata = 8'h04;
    @(posedge clock); #1; m1_req = 1'b0;
    m0_req = 1'b1; m0_write = 1'b1; m0_rs = 2'd0; m0_wdata = 8'h99;
    @(posedge clock); #1; m0_req = 1'b0;
    sent = 1;
    for (int c = 0; c < 60 && (n_rr - n0) < 4; c++) begin
      @(posedge clock); #1;
      m1_req = 1'b0;
      if (sent < 3 && !rr_m1_busy) begin
        m1_req = 1'b1; m1_wdata = 8'(8'h04 + sent); sent++;
      end
      if ((n_rr - n0) >= 3) m1_lock = 1'b0;
    end
    m1_req = 1'b0;
    repeat (4) @(posedge clock);
    @(negedge clock);
    chk("lock_rr_count", n_rr - n0, 4);
    chk("lock_fp_count", n_fp - f0, 4);
    for (int i = 0; i < 4; i++) begin
      chk("lock_rr_order", ord_rr[n0 + i], (i < 3) ? 1 : 0);
      chk("lock_fp_order", ord_fp[f0 + i], (i < 3) ? 1 : 0);
    end
    e_sync = 1'b0;
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
